// File: rtl/dragon_body_controller_pkg.sv
// Shared game package: grid geometry, heading encodings and {y,x} position
// field helpers used by the dragon, player and sheep movers.
package dragon_body_controller_pkg;

    localparam int POS_W     = 8;   // packed position {y[3:0], x[3:0]}
    localparam int XY_W      = 4;   // width of each coordinate field
    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    function automatic logic [XY_W-1:0] pos_x(input logic [POS_W-1:0] p);
        return p[XY_W-1:0];
    endfunction

    function automatic logic [XY_W-1:0] pos_y(input logic [POS_W-1:0] p);
        return p[POS_W-1:XY_W];
    endfunction

    function automatic logic [POS_W-1:0] mk_pos(input logic [XY_W-1:0] y,
                                                input logic [XY_W-1:0] x);
        return {y, x};
    endfunction

    // Opposite heading: the encoding places opposites two apart, so flip bit 1.
    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/dragon_head_stepper.sv
// Combinational one-cell mover with toroidal wrap.
//   pos_i : current position {y,x}
//   dir_i : heading (up/right/down/left)
//   pos_o : position one cell along dir_i, wrapped into the grid
module dragon_head_stepper
    import dragon_body_controller_pkg::*;
#(
    parameter int GRID_COLS = dragon_body_controller_pkg::GRID_COLS,
    parameter int GRID_ROWS = dragon_body_controller_pkg::GRID_ROWS
) (
    input  logic [POS_W-1:0] pos_i,
    input  dir_e             dir_i,
    output logic [POS_W-1:0] pos_o
);

    logic [XY_W-1:0] x, y, nx, ny;

    always_comb begin
        x  = pos_x(pos_i);
        y  = pos_y(pos_i);
        nx = x;
        ny = y;
        case (dir_i)
            DIR_UP:    ny = (y == '0) ? XY_W'(GRID_ROWS-1) : y - XY_W'(1);
            DIR_RIGHT: nx = (x == XY_W'(GRID_COLS-1)) ? '0 : x + XY_W'(1);
            DIR_DOWN:  ny = (y == XY_W'(GRID_ROWS-1)) ? '0 : y + XY_W'(1);
            DIR_LEFT:  nx = (x == '0) ? XY_W'(GRID_COLS-1) : x - XY_W'(1);
            default:   ;
        endcase
        pos_o = mk_pos(ny, nx);
    end

endmodule

// File: rtl/dragon_body_controller.sv
// Dragon body controller: owns segment positions and the active-segment mask.
// All state moves only on frame_end, so outputs are stable for a full frame
// while the collision detector scans the segments.
//   clk, reset              : clock, async active-low reset
//   frame_end               : end-of-frame strobe (sole update enable)
//   move_dir                : requested heading
//   sheep/swordDragonCollision : detector flags for the finished frame
//   dragonSegmentPositions  : {segN-1..seg0}, 8 bits {y,x} each
//   activeDragonSegments    : thermometer mask of live segments
//   dragon_length           : popcount of the mask
//   dragon_dead             : sticky, set when the mask empties
module dragon_body_controller
    import dragon_body_controller_pkg::*;
#(
    parameter int               NUM_SEGMENTS = 7,
    parameter int               GRID_COLS    = dragon_body_controller_pkg::GRID_COLS,
    parameter int               GRID_ROWS    = dragon_body_controller_pkg::GRID_ROWS,
    parameter int               MOVE_PERIOD  = 4,
    parameter int               INIT_LEN     = 1,
    parameter logic [POS_W-1:0] INIT_POS     = 8'h55,
    localparam int              LEN_W        = $clog2(NUM_SEGMENTS+1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_end,
    input  logic [1:0]                    move_dir,
    input  logic                          sheepDragonCollision,
    input  logic                          swordDragonCollision,
    output logic [NUM_SEGMENTS*POS_W-1:0] dragonSegmentPositions,
    output logic [NUM_SEGMENTS-1:0]       activeDragonSegments,
    output logic [LEN_W-1:0]              dragon_length,
    output logic                          dragon_dead
);

    localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [NUM_SEGMENTS-1:0] MASK_INIT =
        NUM_SEGMENTS'((64'd1 << INIT_LEN) - 64'd1);

    logic [NUM_SEGMENTS-1:0][POS_W-1:0] seg_q, seg_d;
    logic [NUM_SEGMENTS-1:0]            mask_q, mask_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    dir_e                               heading_q, heading_d;
    logic                               dead_q, dead_d;
    logic                               step;
    logic [POS_W-1:0]                   head_nxt;
    logic [LEN_W-1:0]                   len_c;

    // Head moves along the heading accepted on this same frame_end.
    dragon_head_stepper #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS)
    ) u_head_stepper (
        .pos_i (seg_q[0]),
        .dir_i (heading_d),
        .pos_o (head_nxt)
    );

    // A direct U-turn would run the head into segment 1, so it is dropped.
    always_comb begin
        heading_d = heading_q;
        if (frame_end && !dead_q && (dir_e'(move_dir) != reverse_dir(heading_q)))
            heading_d = dir_e'(move_dir);
    end

    always_comb begin
        seg_d  = seg_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        dead_d = dead_q;
        step   = 1'b0;
        if (frame_end && !dead_q) begin
            step  = (cnt_q == CNT_W'(MOVE_PERIOD-1));
            cnt_d = step ? '0 : cnt_q + CNT_W'(1);
            // Whole array shifts, live or not, so a grown segment
            // reappears at the previous tail cell.
            if (step)
                seg_d = {seg_q[NUM_SEGMENTS-2:0], head_nxt};
            // Simultaneous sheep and sword hits cancel out.
            if (sheepDragonCollision && !swordDragonCollision) begin
                mask_d = {mask_q[NUM_SEGMENTS-2:0], 1'b1};
            end else if (swordDragonCollision && !sheepDragonCollision) begin
                mask_d = mask_q >> 1;
                dead_d = (mask_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q     <= {NUM_SEGMENTS{INIT_POS}};
            mask_q    <= MASK_INIT;
            cnt_q     <= '0;
            heading_q <= DIR_RIGHT;
            dead_q    <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            heading_q <= heading_d;
            dead_q    <= dead_d;
        end
    end

    always_comb begin
        len_c = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++)
            len_c = len_c + LEN_W'(mask_q[i]);
    end

    assign dragonSegmentPositions = seg_q;
    assign activeDragonSegments   = mask_q;
    assign dragon_length          = len_c;
    assign dragon_dead            = dead_q;

endmodule
